// File: rtl/t07_wire_cut_judge.sv
// Wire-game judge: builds a random 3..6 wire layout on game entry, then judges
// SELECT cuts from the wire locator, tracking cut wires, strikes and win/lose.
// Latency: layout ready 3 cycles after entry; cut results registered 1 cycle after the cut.
// Backpressure: none; strobe events outside ARMED (or not forming a legal cut) are dropped.
//
// Ports:
//   clk, nrst            clock (rising edge) and asynchronous active-low reset
//   playing_state_in     game selector, 3'b010 selects this game
//   strobe, button       one-cycle button event; only SELECT (6'b000001) acts
//   wire_pos             wire index chosen by the locator
//   wire_num             wire count of current layout (0 when idle)
//   wire_colors          3-bit colour per wire, wire i at [3i+2:3i], unused wires 0
//   cut_mask             bit i set once wire i has been cut
//   wire_cleared         level, correct wire cut
//   wire_failed          level, strike limit reached
//   strike               one-cycle pulse per wrong cut
//   strike_count         wrong cuts so far, saturating at MAX_STRIKES

module t07_wire_cut_judge #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [1:0]  MAX_STRIKES = 2'd3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [2:0]  playing_state_in,
  input  logic        strobe,
  input  logic [5:0]  button,
  input  logic [2:0]  wire_pos,
  output logic [2:0]  wire_num,
  output logic [17:0] wire_colors,
  output logic [5:0]  cut_mask,
  output logic        wire_cleared,
  output logic        wire_failed,
  output logic        strike,
  output logic [1:0]  strike_count
);

  localparam logic [2:0]  GAME_WIRE = 3'b010;
  localparam logic [5:0]  BTN_SEL   = 6'b000001;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE, GEN_NUM, GEN_COL, ARMED, CLEARED, FAILED
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  wire_num_q, wire_num_d;
  logic [17:0] wire_colors_q, wire_colors_d;
  logic [5:0]  cut_mask_q, cut_mask_d;
  logic        wire_cleared_q, wire_cleared_d;
  logic        wire_failed_q, wire_failed_d;
  logic        strike_q, strike_d;
  logic [1:0]  strike_count_q, strike_count_d;
  logic [2:0]  target_q, target_d;

  logic [17:0] raw_col;
  logic [17:0] masked_col;
  logic [2:0]  red_tgt;
  logic [7:0]  mask_ext;
  logic        cut_evt;

  // Widened copy so an out-of-range wire_pos (6, 7) indexes a zero bit.
  assign mask_ext = {2'b00, cut_mask_q};
  assign cut_evt  = strobe && (button == BTN_SEL) && (wire_pos < wire_num_q)
                    && !mask_ext[wire_pos];

  // Layout colours and the winning wire, derived from the current LFSR value.
  // The loop overwrites upwards so the highest red index wins.
  always_comb begin
    raw_col    = {lfsr_q[1:0], lfsr_q};
    masked_col = '0;
    red_tgt    = wire_num_q - 3'd1;
    for (int i = 0; i < 6; i++) begin
      if (3'(i) < wire_num_q) begin
        masked_col[3*i +: 3] = raw_col[3*i +: 3];
        if (raw_col[3*i +: 3] == 3'd1) begin
          red_tgt = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    lfsr_d         = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    wire_num_d     = wire_num_q;
    wire_colors_d  = wire_colors_q;
    cut_mask_d     = cut_mask_q;
    wire_cleared_d = wire_cleared_q;
    wire_failed_d  = wire_failed_q;
    strike_d       = 1'b0;
    strike_count_d = strike_count_q;
    target_d       = target_q;

    if (state_q != IDLE && playing_state_in != GAME_WIRE) begin
      // Leaving the game wins over any simultaneous cut.
      state_d        = IDLE;
      wire_num_d     = '0;
      wire_colors_d  = '0;
      cut_mask_d     = '0;
      wire_cleared_d = 1'b0;
      wire_failed_d  = 1'b0;
      strike_count_d = '0;
      target_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (playing_state_in == GAME_WIRE) begin
            state_d = GEN_NUM;
          end
        end
        GEN_NUM: begin
          wire_num_d = 3'd3 + {1'b0, lfsr_q[1:0]};
          state_d    = GEN_COL;
        end
        GEN_COL: begin
          wire_colors_d = masked_col;
          target_d      = red_tgt;
          state_d       = ARMED;
        end
        ARMED: begin
          if (cut_evt) begin
            cut_mask_d = cut_mask_q | (6'd1 << wire_pos);
            if (wire_pos == target_q) begin
              wire_cleared_d = 1'b1;
              state_d        = CLEARED;
            end else begin
              strike_d = 1'b1;
              if (strike_count_q != MAX_STRIKES) begin
                strike_count_d = strike_count_q + 2'd1;
              end
              if (strike_count_d == MAX_STRIKES) begin
                wire_failed_d = 1'b1;
                state_d       = FAILED;
              end
            end
          end
        end
        CLEARED: ;
        FAILED:  ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      lfsr_q         <= SEED;
      wire_num_q     <= '0;
      wire_colors_q  <= '0;
      cut_mask_q     <= '0;
      wire_cleared_q <= 1'b0;
      wire_failed_q  <= 1'b0;
      strike_q       <= 1'b0;
      strike_count_q <= '0;
      target_q       <= '0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      wire_num_q     <= wire_num_d;
      wire_colors_q  <= wire_colors_d;
      cut_mask_q     <= cut_mask_d;
      wire_cleared_q <= wire_cleared_d;
      wire_failed_q  <= wire_failed_d;
      strike_q       <= strike_d;
      strike_count_q <= strike_count_d;
      target_q       <= target_d;
    end
  end

  assign wire_num     = wire_num_q;
  assign wire_colors  = wire_colors_q;
  assign cut_mask     = cut_mask_q;
  assign wire_cleared = wire_cleared_q;
  assign wire_failed  = wire_failed_q;
  assign strike       = strike_q;
  assign strike_count = strike_count_q;

endmodule

// File: tb/tb_t07_wire_cut_judge.sv
// Self-checking bench for t07_wire_cut_judge: directed layouts are found by
// predicting the LFSR ahead of game entry, random cut sequences are scored
// against a behavioural judge model.

module tb_t07_wire_cut_judge;

  localparam logic [5:0] SEL = 6'b000001;

  logic        clk = 1'b0;
  logic        nrst;
  logic [2:0]  playing_state_in;
  logic        strobe;
  logic [5:0]  button;
  logic [2:0]  wire_pos;
  logic [2:0]  wire_num;
  logic [17:0] wire_colors;
  logic [5:0]  cut_mask;
  logic        wire_cleared;
  logic        wire_failed;
  logic        strike;
  logic [1:0]  strike_count;

  t07_wire_cut_judge dut (
    .clk(clk), .nrst(nrst), .playing_state_in(playing_state_in),
    .strobe(strobe), .button(button), .wire_pos(wire_pos),
    .wire_num(wire_num), .wire_colors(wire_colors), .cut_mask(cut_mask),
    .wire_cleared(wire_cleared), .wire_failed(wire_failed),
    .strike(strike), .strike_count(strike_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference LFSR: free-running sequence from SEED, read only at negedges.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] ref_lfsr;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) ref_lfsr <= 16'hACE1;
    else       ref_lfsr <= lfsr_step(ref_lfsr);
  end

  // Judge model state
  logic [2:0]  m_num;
  logic [17:0] m_cols;
  logic [2:0]  m_tgt;
  logic [5:0]  m_mask;
  int          m_cnt;
  logic        m_clr, m_fail, m_strike;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".num"},   32'(wire_num),     32'(m_num));
    check({tag, ".cols"},  32'(wire_colors),  32'(m_cols));
    check({tag, ".mask"},  32'(cut_mask),     32'(m_mask));
    check({tag, ".clr"},   32'(wire_cleared), 32'(m_clr));
    check({tag, ".fail"},  32'(wire_failed),  32'(m_fail));
    check({tag, ".strk"},  32'(strike),       32'(m_strike));
    check({tag, ".cnt"},   32'(strike_count), m_cnt);
  endtask

  task automatic model_clear();
    m_num = '0; m_cols = '0; m_tgt = '0; m_mask = '0;
    m_cnt = 0; m_clr = 1'b0; m_fail = 1'b0; m_strike = 1'b0;
  endtask

  // Layout produced if the game is entered with the LFSR currently at l0:
  // count from the next state, colours from the one after. Target is found by
  // scanning downwards for the first red wire.
  task automatic predict(input logic [15:0] l0, output logic [2:0] num,
                         output logic [17:0] cols, output logic [2:0] tgt);
    logic [15:0] l1, l2;
    logic [17:0] raw;
    l1   = lfsr_step(l0);
    l2   = lfsr_step(l1);
    num  = 3'd3 + {1'b0, l1[1:0]};
    raw  = {l2[1:0], l2};
    cols = '0;
    for (int i = 0; i < int'(num); i++) cols[3*i +: 3] = raw[3*i +: 3];
    tgt = num - 3'd1;
    for (int i = int'(num) - 1; i >= 0; i--) begin
      if (raw[3*i +: 3] == 3'd1) begin
        tgt = 3'(i);
        break;
      end
    end
  endtask

  function automatic logic [2:0] col_of(input logic [17:0] c, input int i);
    return c[3*i +: 3];
  endfunction

  // Wait (in IDLE, at a negedge) until entering now yields the wanted layout.
  // kind 0: red at 1 and 3, target 3, >= 5 wires; 1: 4 wires, no red;
  // 2: anything; 3: target not wire 0.
  task automatic find_layout(input int kind);
    logic [2:0] n, t;
    logic [17:0] c;
    bit hit, any_red;
    hit = 1'b0;
    for (int k = 0; k < 20000 && !hit; k++) begin
      predict(ref_lfsr, n, c, t);
      any_red = 1'b0;
      for (int i = 0; i < int'(n); i++) if (col_of(c, i) == 3'd1) any_red = 1'b1;
      case (kind)
        0: hit = (n >= 3'd5) && (col_of(c, 1) == 3'd1) && (col_of(c, 3) == 3'd1) && (t == 3'd3);
        1: hit = (n == 3'd4) && !any_red;
        3: hit = (t != 3'd0);
        default: hit = 1'b1;
      endcase
      if (!hit) @(negedge clk);
    end
    check("find_layout", 32'(hit), 32'd1);
  endtask

  // Enter the game holding a SELECT cut of wire 0 through the generation
  // cycles; none of those may register.
  task automatic enter(input string tag);
    logic [2:0] n, t;
    logic [17:0] c;
    predict(ref_lfsr, n, c, t);
    playing_state_in = 3'b010;
    strobe = 1'b1; button = SEL; wire_pos = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check({tag, ".num_early"}, 32'(wire_num), 32'(n));
    check({tag, ".cols_early"}, 32'(wire_colors), 32'd0);
    check({tag, ".range"}, 32'(wire_num >= 3'd3 && wire_num <= 3'd6), 32'd1);
    @(negedge clk);
    strobe = 1'b0; button = '0;
    model_clear();
    m_num = n; m_cols = c; m_tgt = t;
    check_all(tag);
  endtask

  task automatic do_event(input logic s, input logic [5:0] b, input logic [2:0] p,
                          input string tag);
    strobe = s; button = b; wire_pos = p;
    m_strike = 1'b0;
    if (!m_clr && !m_fail && s && b == SEL && p < m_num && !m_mask[p]) begin
      m_mask[p] = 1'b1;
      if (p == m_tgt) m_clr = 1'b1;
      else begin
        m_strike = 1'b1;
        if (m_cnt < 3) m_cnt++;
        if (m_cnt == 3) m_fail = 1'b1;
      end
    end
    @(negedge clk);
    strobe = 1'b0; button = '0;
    check_all(tag);
  endtask

  task automatic leave(input bit with_cut, input string tag);
    playing_state_in = 3'b000;
    if (with_cut) begin
      strobe = 1'b1; button = SEL; wire_pos = m_tgt;
    end
    @(negedge clk);
    strobe = 1'b0; button = '0;
    model_clear();
    check_all(tag);
  endtask

  initial begin
    nrst = 1'b0;
    playing_state_in = 3'b000;
    strobe = 1'b0; button = '0; wire_pos = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Red at 1 and 3: cutting 3 wins at once, later cuts ignored.
    find_layout(0);
    enter("redA");
    do_event(1'b1, SEL, 3'd3, "win3");
    check("win3.mask_lit", 32'(cut_mask), 32'h08);
    do_event(1'b1, SEL, 3'd0, "after_win");
    leave(1'b0, "leave1");

    // Same kind of layout: three wrong cuts fail the module.
    find_layout(0);
    enter("redB");
    do_event(1'b1, SEL, 3'd0, "wrong0");
    do_event(1'b1, SEL, 3'd2, "wrong2");
    do_event(1'b1, SEL, 3'd4, "wrong4");
    check("fail_lit", 32'(wire_failed), 32'd1);
    do_event(1'b1, SEL, 3'd3, "after_fail");
    leave(1'b0, "leave2");

    // Double cut and non-SELECT button give only one strike.
    find_layout(3);
    enter("dbl");
    do_event(1'b1, SEL, 3'd0, "dbl.first");
    do_event(1'b1, SEL, 3'd0, "dbl.again");
    do_event(1'b1, 6'b000010, 3'd1, "dbl.otherbtn");
    do_event(1'b0, SEL, 3'd1, "dbl.nostrobe");
    do_event(1'b1, SEL, 3'd7, "dbl.outrange");
    leave(1'b0, "leave3");

    // No red, four wires: last wire is the target.
    find_layout(1);
    enter("nored");
    do_event(1'b1, SEL, 3'd2, "nored.cut2");
    do_event(1'b1, SEL, 3'd3, "nored.cut3");
    leave(1'b0, "leave4");

    // Leaving on the same edge as the winning cut discards the cut.
    find_layout(2);
    enter("race");
    leave(1'b1, "race.leave");
    find_layout(2);
    enter("reenter");

    // Asynchronous reset mid-game, checked before the next clock edge.
    do_event(1'b1, SEL, 3'd6, "pre_rst");
    #2 nrst = 1'b0;
    playing_state_in = 3'b000;
    #1 model_clear();
    check_all("async_rst");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Random sessions.
    for (int r = 0; r < 10; r++) begin
      find_layout(2);
      enter("rnd.enter");
      for (int e = 0; e < 12; e++) begin
        logic s;
        logic [5:0] b;
        logic [2:0] p;
        s = ($urandom_range(0, 3) != 0);
        b = ($urandom_range(0, 3) == 0) ? (6'b000001 << $urandom_range(1, 5)) : SEL;
        p = 3'($urandom_range(0, 7));
        do_event(s, b, p, "rnd.ev");
      end
      leave($urandom_range(0, 1) == 1, "rnd.leave");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/t07_wire_cut_judge.md
# t07_wire_cut_judge

Wire-game judge that sits directly downstream of the wire locator. It generates a random wire layout on game entry and consumes the locator's wire_pos together with the SELECT strobe to cut wires. It decides whether the cut is the correct wire, and drives wire_num and wire_cleared back to the locator, plus colour, cut-mask and strike information to the display and top FSM.

## Interface
- SEED, 16'hACE1, LFSR reset value (must be nonzero)
- MAX_STRIKES, 2'd3, wrong cuts that fail the module
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- playing_state_in  in  3  game selector; 3'b010 = wire game active
- strobe  in  1  one-cycle button-event qualifier
- button  in  6  one-hot button code; SELECT = 6'b000001, all other codes ignored
- wire_pos  in  3  selected wire index from locator
- wire_num  out  3  wire count of current layout, 3..6
- wire_colors  out  18  3-bit colour per wire; wire i at [3i+2:3i]; wires ≥ wire_num read 0
- cut_mask  out  6  bit i = wire i cut
- wire_cleared  out  1  level: correct wire cut
- wire_failed  out  1  level: strike limit reached
- strike  out  1  one-cycle pulse per wrong cut
- strike_count  out  2  wrong cuts so far

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11 (shift right, XOR 16'hB400 when LSB = 1). Free-runs every clock from reset; never reloaded after reset.
- FSM states: IDLE, GEN_NUM, GEN_COL, ARMED, CLEARED, FAILED.
- IDLE: all outputs at reset values. When playing_state_in == 3'b010, go to GEN_NUM.
- GEN_NUM: wire_num <= 3 + lfsr[1:0]; go to GEN_COL.
- GEN_COL: raw colours = {lfsr[1:0], lfsr[15:0]}; colours for index ≥ wire_num are masked to 0. Compute target = highest index < wire_num whose colour == 3'd1 (red). If there is no red wire, target = wire_num−1. Go to ARMED.
- ARMED: a cut event is strobe && button == SELECT && wire_pos < wire_num && !cut_mask[wire_pos].
  - Cut event: set cut_mask[wire_pos].
  - If wire_pos == target: go to CLEARED.
  - Otherwise: pulse strike and increment strike_count. If the new count == MAX_STRIKES, go to FAILED.
  - Non-cut events (already-cut wire, out-of-range pos, other buttons, strobe low) leave state and outputs unchanged.
- CLEARED: wire_cleared = 1, holds. Further events are ignored.
- FAILED: wire_failed = 1, holds. Further events are ignored.
- From any non-IDLE state, playing_state_in != 3'b010 returns the FSM to IDLE next cycle. All outputs return to reset values, so re-entry produces a fresh layout.
- target is internal and not exported.

## Timing
- Reset values: wire_num 0, wire_colors 0, cut_mask 0, wire_cleared 0, wire_failed 0, strike 0, strike_count 0, LFSR = SEED, state IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Entry latency: playing_state_in becomes 3'b010 at edge N; GEN_NUM at N+1; wire_num valid after N+2; colours valid and ARMED after N+3.
- Cut events before ARMED are ignored.
- A cut sampled at edge M: cut_mask, wire_cleared/wire_failed, strike and strike_count update after edge M. strike is high exactly one cycle.
- The locator must see wire_cleared in the cycle after the winning cut.
- Leaving the wire game (playing_state_in != 3'b010) at the same edge as a cut: the leave wins, the cut is discarded, and state goes to IDLE.
- strike_count saturates at MAX_STRIKES and never wraps.
- Reset asserted mid-game: immediate asynchronous return to reset values.

## Test plan
- Reset, then playing_state_in = 3'b010: wire_num is in 3..6 at cycle 2; wire_colors bits above 3·wire_num are 0; cut_mask = 0.
- Force a layout with SEED so that the generated colours contain red at indices 1 and 3; cut wire 3 -> cut_mask = 6'b001000, wire_cleared = 1, strike never pulses.
- Same layout, cut wires 0, 2, 4 -> three single-cycle strike pulses, strike_count = 3, wire_failed = 1 after the third cut, then ignore a further cut of 3.
- Cut wire 0 twice, then press a non-SELECT button with strobe -> exactly one strike, cut_mask = 6'b000001.
- Layout with no red wire and wire_num = 4 -> cutting wire 3 clears; cutting wire 2 strikes.
- Mid-game, drive playing_state_in = 3'b000 on the same edge as a cut -> next cycle all outputs are 0, state is IDLE; re-entering generates a new layout; asserting nrst mid-ARMED clears outputs asynchronously.
